// File: rtl/vga_if.sv
// VGA pixel-stream bundle passed from the timing generator through the drawing stages.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing source: counts, blanking, syncs and line/frame strobes,
// all registered from the next counter values so every field describes the same pixel.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FRONT    = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BACK     = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FRONT    = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BACK     = 23,
  parameter bit H_SYNC_POS = 1'b1,
  parameter bit V_SYNC_POS = 1'b1
) (
  input  logic clk,
  input  logic rst,
  vga_if.out   out,
  output logic line_start,
  output logic frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  // Window bounds are 12 bits wide so a sync ending exactly at 2048 does not wrap to 0.
  localparam logic [11:0] HB_START = 12'(H_ACTIVE);
  localparam logic [11:0] VB_START = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FRONT + V_SYNC);

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_timing
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
    end
  endgenerate

  logic [10:0] r_hcount;
  logic [10:0] r_vcount;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_hblnk;
  logic        r_vblnk;
  logic        r_line_start;
  logic        r_frame_start;

  logic        w_h_wrap;
  logic        w_v_wrap;
  logic [10:0] w_hcount_next;
  logic [10:0] w_vcount_next;
  logic [11:0] w_hx;
  logic [11:0] w_vx;
  logic        w_hsync_on;
  logic        w_vsync_on;

  always_comb begin
    w_h_wrap      = (r_hcount == H_LAST);
    w_v_wrap      = (r_vcount == V_LAST);
    w_hcount_next = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
    w_vcount_next = r_vcount;
    if (w_h_wrap) begin
      w_vcount_next = w_v_wrap ? 11'd0 : r_vcount + 11'd1;
    end
    w_hx       = {1'b0, w_hcount_next};
    w_vx       = {1'b0, w_vcount_next};
    w_hsync_on = (w_hx >= HS_START) && (w_hx < HS_END);
    w_vsync_on = (w_vx >= VS_START) && (w_vx < VS_END);
  end

  // The reset pixel (0,0) is never re-entered without a wrap, so strobes stay low for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hblnk       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_hsync       <= ~H_SYNC_POS;
      r_vsync       <= ~V_SYNC_POS;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hcount      <= w_hcount_next;
      r_vcount      <= w_vcount_next;
      r_hblnk       <= (w_hx >= HB_START);
      r_vblnk       <= (w_vx >= VB_START);
      r_hsync       <= w_hsync_on ? H_SYNC_POS : ~H_SYNC_POS;
      r_vsync       <= w_vsync_on ? V_SYNC_POS : ~V_SYNC_POS;
      r_line_start  <= (w_hcount_next == 11'd0);
      r_frame_start <= (w_hcount_next == 11'd0) && (w_vcount_next == 11'd0);
    end
  end

  assign out.hcount  = r_hcount;
  assign out.vcount  = r_vcount;
  assign out.hblnk   = r_hblnk;
  assign out.vblnk   = r_vblnk;
  assign out.hsync   = r_hsync;
  assign out.vsync   = r_vsync;
  assign out.rgb     = 12'h000;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance plus a shrunken, inverted-sync instance
// whose whole frames fit in a short run; a per-cycle scoreboard plus directed event checks.
module tb_vga_timing_gen;
  localparam int D_HT = 1056;
  localparam int D_VT = 628;
  localparam int SH_A = 8, SH_F = 2, SH_S = 3, SH_B = 3;
  localparam int SV_A = 6, SV_F = 1, SV_S = 2, SV_B = 2;
  localparam int S_HT = 16;
  localparam int S_VT = 11;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        ls;
    logic        fs;
    logic [11:0] rgb;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  vga_if vga_d ();
  vga_if vga_s ();
  logic d_ls, d_fs, s_ls, s_fs;

  vga_timing_gen u_dut (
    .clk(clk), .rst(rst), .out(vga_d), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(SH_A), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
    .V_ACTIVE(SV_A), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
    .H_SYNC_POS(1'b0), .V_SYNC_POS(1'b0)
  ) u_small (
    .clk(clk), .rst(rst), .out(vga_s), .line_start(s_ls), .frame_start(s_fs)
  );

  obs_t d_obs, s_obs;
  always_comb begin
    d_obs = '{h: vga_d.hcount, v: vga_d.vcount, hs: vga_d.hsync, vs: vga_d.vsync,
              hb: vga_d.hblnk, vb: vga_d.vblnk, ls: d_ls, fs: d_fs, rgb: vga_d.rgb};
    s_obs = '{h: vga_s.hcount, v: vga_s.vcount, hs: vga_s.hsync, vs: vga_s.vsync,
              hb: vga_s.hblnk, vb: vga_s.vblnk, ls: s_ls, fs: s_fs, rgb: vga_s.rgb};
  end

  function automatic obs_t mk_obs(int h, int v, int ha, int hf, int hsw,
                                  int va, int vf, int vsw, bit hp, bit vp);
    obs_t o;
    o.h   = 11'(h);
    o.v   = 11'(v);
    o.hb  = (h >= ha);
    o.vb  = (v >= va);
    o.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
    o.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
    o.ls  = (h == 0);
    o.fs  = (h == 0) && (v == 0);
    o.rgb = 12'h000;
    return o;
  endfunction

  function automatic obs_t rst_obs(bit hp, bit vp);
    obs_t o;
    o     = '0;
    o.hs  = ~hp;
    o.vs  = ~vp;
    return o;
  endfunction

  task automatic cmp_obs(string name, obs_t got, obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL sb_%s got h=%0d v=%0d hs/vs/hb/vb/ls/fs=%b%b%b%b%b%b rgb=%h exp h=%0d v=%0d hs/vs/hb/vb/ls/fs=%b%b%b%b%b%b rgb=%h",
               name, got.h, got.v, got.hs, got.vs, got.hb, got.vb, got.ls, got.fs, got.rgb,
               exp.h, exp.v, exp.hs, exp.vs, exp.hb, exp.vb, exp.ls, exp.fs, exp.rgb);
    end
  endtask

  task automatic check(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end else begin
      $display("check %s got=%0d ok", name, got);
    end
  endtask

  // Reference raster model: pushes the expected pixel for each active edge.
  obs_t q_d[$];
  obs_t q_s[$];
  int md_h = 0, md_v = 0, ms_h = 0, ms_v = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_h = 0; md_v = 0; ms_h = 0; ms_v = 0;
      q_d.delete();
      q_s.delete();
    end else begin
      if (md_h == D_HT - 1) begin
        md_h = 0;
        md_v = (md_v == D_VT - 1) ? 0 : md_v + 1;
      end else begin
        md_h = md_h + 1;
      end
      if (ms_h == S_HT - 1) begin
        ms_h = 0;
        ms_v = (ms_v == S_VT - 1) ? 0 : ms_v + 1;
      end else begin
        ms_h = ms_h + 1;
      end
      q_d.push_back(mk_obs(md_h, md_v, 800, 40, 128, 600, 1, 4, 1'b1, 1'b1));
      q_s.push_back(mk_obs(ms_h, ms_v, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S, 1'b0, 1'b0));
    end
  end

  always @(negedge clk) begin
    obs_t e_d;
    obs_t e_s;
    if (!rst || q_d.size() == 0) e_d = rst_obs(1'b1, 1'b1);
    else                         e_d = q_d.pop_front();
    if (!rst || q_s.size() == 0) e_s = rst_obs(1'b0, 1'b0);
    else                         e_s = q_s.pop_front();
    cmp_obs("dflt", d_obs, e_d);
    cmp_obs("small", s_obs, e_s);
  end

  initial begin
    int  n;
    int  hs_cnt, hs_first, hs_last, hb_rise, hb_fall;
    int  fs1, fs2, d_fs_cnt, s_vs_cnt, s_vb_cnt, s_hs_cnt;
    bit  prev_hb, found;
    hs_cnt = 0; hs_first = -1; hs_last = -1; hb_rise = -1; hb_fall = -1;
    fs1 = -1; fs2 = -1; d_fs_cnt = 0; s_vs_cnt = 0; s_vb_cnt = 0; s_hs_cnt = 0;
    prev_hb = 1'b0;

    repeat (5) @(negedge clk);
    check("rst_d_hcount", int'(vga_d.hcount), 0);
    check("rst_d_hsync", int'(vga_d.hsync), 0);
    check("rst_d_vsync", int'(vga_d.vsync), 0);
    check("rst_s_hsync", int'(vga_s.hsync), 1);
    check("rst_s_vsync", int'(vga_s.vsync), 1);
    check("rst_d_ls", int'(d_ls), 0);

    #2 rst = 1'b1;
    for (n = 1; n <= 2200; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("rel_d_hcount", int'(vga_d.hcount), 1);
        check("rel_d_vcount", int'(vga_d.vcount), 0);
        check("rel_d_ls", int'(d_ls), 0);
        check("rel_s_hcount", int'(vga_s.hcount), 1);
      end
      if (n == 1056) begin
        check("wrap_d_hcount", int'(vga_d.hcount), 0);
        check("wrap_d_vcount", int'(vga_d.vcount), 1);
        check("wrap_d_ls", int'(d_ls), 1);
      end
      if (n == 1057) begin
        check("wrap_d_ls_drop", int'(d_ls), 0);
        check("wrap_d_hcount_next", int'(vga_d.hcount), 1);
      end
      if (vga_d.vcount == 0 && vga_d.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(vga_d.hcount);
        hs_last = int'(vga_d.hcount);
      end
      if (!prev_hb && vga_d.hblnk && hb_rise < 0) hb_rise = int'(vga_d.hcount);
      if (prev_hb && !vga_d.hblnk && hb_fall < 0) hb_fall = int'(vga_d.hcount);
      prev_hb = vga_d.hblnk;
      if (d_fs) d_fs_cnt++;
      if (s_fs) begin
        if (fs1 < 0) fs1 = n;
        else if (fs2 < 0) fs2 = n;
      end
      if (n <= S_HT * S_VT) begin
        if (!vga_s.vsync) s_vs_cnt++;
        if (vga_s.vblnk) s_vb_cnt++;
        if (!vga_s.hsync) s_hs_cnt++;
      end
    end
    check("d_hsync_cycles", hs_cnt, 128);
    check("d_hsync_first", hs_first, 840);
    check("d_hsync_last", hs_last, 967);
    check("d_hblnk_rise", hb_rise, 800);
    check("d_hblnk_fall", hb_fall, 0);
    check("d_frame_start_none", d_fs_cnt, 0);
    check("s_first_fs_edge", fs1, 176);
    check("s_second_fs_edge", fs2, 352);
    check("s_vsync_cycles", s_vs_cnt, 32);
    check("s_vblnk_cycles", s_vb_cnt, 80);
    check("s_hsync_cycles", s_hs_cnt, 33);

    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (vga_s.vcount == 3 && vga_s.hcount == 5) found = 1'b1;
    end
    check("midrst_reached", int'(found), 1);
    #2 rst = 1'b0;
    #1;
    check("async_s_hcount", int'(vga_s.hcount), 0);
    check("async_s_vcount", int'(vga_s.vcount), 0);
    check("async_s_hsync", int'(vga_s.hsync), 1);
    check("async_d_hcount", int'(vga_d.hcount), 0);
    check("async_d_hsync", int'(vga_d.hsync), 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    for (n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) check("midrst_rel_d_hcount", int'(vga_d.hcount), 1);
      if (s_fs) break;
    end
    check("midrst_fs_edges", n, 176);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
